// File: rtl/alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_iter                                                   |
// | Description : 32-bit ALU with an iterative shifter and valid/ready       |
// |               handshakes on both sides. It runs one operation at a time. |
// |               Non-shift operations complete in one cycle. Shifts step    |
// |               one bit per cycle.                                          |
// | Macro       : ALU_ITER_FAST_SHIFT_EN - when defined, shifts use a        |
// |               single-cycle barrel shifter and SHIFT is never entered.    |
// | Ports       : clk, reset    - clock, synchronous active-high reset       |
// |               flush         - abort any in-flight operation              |
// |               in_valid/in_ready - operation handshake (ready in IDLE)    |
// |               ALUControl, SrcA, SrcB - opcode and operands               |
// |               out_valid/out_ready - result handshake (valid in DONE)     |
// |               ALUResult, Zero, out_illegal - registered result flags     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        out_illegal
);

  localparam logic [4:0] c_OP_ADD  = 5'b00000;
  localparam logic [4:0] c_OP_SUB  = 5'b10000;
  localparam logic [4:0] c_OP_AND  = 5'b00001;
  localparam logic [4:0] c_OP_OR   = 5'b00010;
  localparam logic [4:0] c_OP_XOR  = 5'b00011;
  localparam logic [4:0] c_OP_SLL  = 5'b00100;
  localparam logic [4:0] c_OP_SRL  = 5'b00101;
  localparam logic [4:0] c_OP_SRA  = 5'b00110;
  localparam logic [4:0] c_OP_SLT  = 5'b10111;
  localparam logic [4:0] c_OP_SLTU = 5'b11000;
  localparam logic [4:0] c_OP_BLTU = 5'b10010;
  localparam logic [4:0] c_OP_BGEU = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [4:0]  r_op;
  logic [31:0] r_shval;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_illegal;

  logic [4:0]  w_op_next;
  logic [31:0] w_shval_next;
  logic [4:0]  w_cnt_next;
  logic [31:0] w_result_next;
  logic        w_zero_next;
  logic        w_illegal_next;

  logic        w_accept;
  logic        w_is_shift;
  logic        w_legal;
  logic [31:0] w_alu_result;
  logic [31:0] w_shift_step;
`ifdef ALU_ITER_FAST_SHIFT_EN
  logic [31:0] w_barrel;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign ALUResult   = r_result;
  assign Zero        = r_zero;
  assign out_illegal = r_illegal;

  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  // Opcode classification of the presented (not yet latched) operation.
  always_comb begin
    w_is_shift = 1'b0;
    w_legal    = 1'b1;
    case (ALUControl)
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_is_shift = 1'b1;
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR,
      c_OP_SLT, c_OP_SLTU, c_OP_BLTU, c_OP_BGEU: w_is_shift = 1'b0;
      default: w_legal = 1'b0;
    endcase
  end

  // Single-cycle (non-shift) operations on the presented operands.
  always_comb begin
    w_alu_result = 32'd0;
    case (ALUControl)
      c_OP_ADD:  w_alu_result = SrcA + SrcB;
      c_OP_SUB:  w_alu_result = SrcA - SrcB;
      c_OP_AND:  w_alu_result = SrcA & SrcB;
      c_OP_OR:   w_alu_result = SrcA | SrcB;
      c_OP_XOR:  w_alu_result = SrcA ^ SrcB;
      c_OP_SLT:  w_alu_result = {31'd0, ($signed(SrcA) < $signed(SrcB))};
      c_OP_SLTU,
      c_OP_BLTU: w_alu_result = {31'd0, (SrcA < SrcB)};
      c_OP_BGEU: w_alu_result = {31'd0, (SrcA >= SrcB)};
      default:   w_alu_result = 32'd0;
    endcase
  end

`ifdef ALU_ITER_FAST_SHIFT_EN
  always_comb begin
    w_barrel = SrcA;
    case (ALUControl)
      c_OP_SLL: w_barrel = SrcA << SrcB[4:0];
      c_OP_SRL: w_barrel = SrcA >> SrcB[4:0];
      c_OP_SRA: w_barrel = $signed(SrcA) >>> SrcB[4:0];
      default:  w_barrel = SrcA;
    endcase
  end
`endif

  // One-bit shift step on the working value; sra re-inserts the sign bit
  // each step so the final value matches an arithmetic shift by shamt.
  always_comb begin
    w_shift_step = r_shval;
    case (r_op)
      c_OP_SLL: w_shift_step = {r_shval[30:0], 1'b0};
      c_OP_SRL: w_shift_step = {1'b0, r_shval[31:1]};
      c_OP_SRA: w_shift_step = {r_shval[31], r_shval[31:1]};
      default:  w_shift_step = r_shval;
    endcase
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_shval_next   = r_shval;
    w_cnt_next     = r_cnt;
    w_result_next  = r_result;
    w_illegal_next = r_illegal;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_next    = ALUControl;
          w_state_next = S_DONE;
          if (!w_legal) begin
            w_result_next  = 32'd0;
            w_illegal_next = 1'b1;
          end else if (w_is_shift) begin
            w_illegal_next = 1'b0;
`ifdef ALU_ITER_FAST_SHIFT_EN
            w_result_next = w_barrel;
`else
            if (SrcB[4:0] == 5'd0) begin
              w_result_next = SrcA;
            end else begin
              w_shval_next = SrcA;
              w_cnt_next   = SrcB[4:0];
              w_state_next = S_SHIFT;
            end
`endif
          end else begin
            w_illegal_next = 1'b0;
            w_result_next  = w_alu_result;
          end
        end
      end
      S_SHIFT: begin
        w_shval_next = w_shift_step;
        w_cnt_next   = r_cnt - 5'd1;
        // Last step: the counter reaches zero on this edge.
        if (r_cnt == 5'd1) begin
          w_result_next = w_shift_step;
          w_state_next  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Abort: the in-flight operation is dropped; an abandoned shift leaves
    // the visible result untouched because it is only written on the last step.
    if (flush) begin
      w_state_next = S_IDLE;
      w_cnt_next   = 5'd0;
    end
  end

  // Zero always tracks the registered result.
  assign w_zero_next = (w_result_next == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= 5'd0;
      r_shval   <= 32'd0;
      r_cnt     <= 5'd0;
      r_result  <= 32'd0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_shval   <= w_shval_next;
      r_cnt     <= w_cnt_next;
      r_result  <= w_result_next;
      r_zero    <= w_zero_next;
      r_illegal <= w_illegal_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; signals SHALL be as listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 in_valid  input  1  operands and ALUControl presented.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 ALUControl  input  5  operation code from the ALU decoder.
REQ-008 SrcA  input  32  operand A.
REQ-009 SrcB  input  32  operand B; SrcB[4:0] is the shift amount.
REQ-010 out_valid  output  1  result, zero and out_illegal are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 ALUResult  output  32  operation result.
REQ-013 Zero  output  1  high when ALUResult == 0.
REQ-014 out_illegal  output  1  the accepted ALUControl code is not in REQ-016.

Function
REQ-015 States SHALL be IDLE, SHIFT and DONE; in_ready = (state == IDLE).
- Accept when in_valid && in_ready && !flush: latch ALUControl, SrcA, SrcB.
REQ-016 Encodings (32-bit, wrap-around):
- 00000 add; 10000 sub; 00001 and; 00010 or; 00011 xor.
- 00100 sll; 00101 srl; 00110 sra.
- 10111 slt: signed A<B gives 1, else 0.
- 11000 sltu and 10010 bltu: unsigned A<B gives 1, else 0.
- 10001 bgeu: unsigned A>=B gives 1, else 0.
REQ-017 Non-shift codes: accept in cycle T, IDLE->DONE, out_valid high from T+1.
REQ-018 Shift codes, nonzero shamt: IDLE->SHIFT; the shift SHALL proceed one bit position per cycle, decrementing the shift counter.
- SHIFT->DONE when the counter reaches 0; out_valid high from T+1+shamt.
- sra SHALL replicate SrcA[31] on every step.
REQ-019 Shift with shamt == 0 SHALL behave as a non-shift: result = SrcA at T+1.
REQ-020 Illegal code: go to DONE at T+1 with ALUResult = 0, Zero = 1, out_illegal = 1.
REQ-021 In DONE, outputs SHALL hold stable while out_ready is low; out_valid && out_ready -> IDLE next cycle, out_valid low.
REQ-022 out_valid SHALL be high only in DONE; ALUResult, Zero and out_illegal SHALL be don't-care-free (registered) at all times.
REQ-023 flush high in any state: next state IDLE, out_valid low next cycle, in-flight result discarded.
- flush and in_valid in the same cycle: flush wins, the operation is not accepted.
REQ-024 Back-to-back: an operation is never accepted in the same cycle a result is consumed (minimum 2 cycles per operation).

Reset
REQ-025 On reset: state = IDLE, out_valid = 0, ALUResult = 0, Zero = 1, out_illegal = 0, shift counter = 0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no result; reset takes priority over flush and in_valid.

Configuration
REQ-027 Macro ALU_ITER_FAST_SHIFT_EN: when defined, all shifts SHALL use a single-cycle barrel shifter with latency 1, and SHIFT is never entered.
- When not defined, shifts SHALL be iterative per REQ-018.
- Results SHALL be identical in both builds.

Verification
REQ-028 add A=0x7FFFFFFF, B=1 -> ALUResult=0x80000000, Zero=0, out_valid at T+1; sub A=B=5 -> 0, Zero=1.
REQ-029 sra A=0x80000000, B=4 -> 0xF8000000 at T+5 (iterative) or T+1 (FAST); sll B=0 -> A at T+1.
REQ-030 slt A=0xFFFFFFFF, B=1 -> 1; sltu same operands -> 0; bgeu A=3, B=3 -> 1; bltu A=2, B=3 -> 1.
REQ-031 srl B=31 with out_ready low for 5 cycles after DONE -> outputs stable, in_ready low; one handshake -> IDLE next cycle.
REQ-032 flush in SHIFT cycle 3 of a 20-step shift -> IDLE next cycle, no out_valid; a new add is accepted in the following cycle.
REQ-033 ALUControl=11111 -> out_illegal=1, ALUResult=0 at T+1; reset during DONE -> out_valid=0 next cycle.
